// File: rtl/svs_controller.sv
// svs_controller: closed-loop SVS supervisor.
// Periodically triggers the monitor array, captures all ring-oscillator counts,
// scans them serially for the slowest unmasked monitor, compares it against the
// selected target window and issues up/down voltage-step requests over a
// valid/ack handshake.
// Optional feature: define SVS_CONTROLLER_TIMEOUT_EN to add a 1024-cycle
// measurement timeout with a sticky o_timeout flag (tied 0 otherwise).
module svs_controller #(
    parameter int NB_MONITOR = 30,
    parameter int COUNT_W    = 16,
    parameter int TARGET_W   = 3,
    parameter int IDX_W      = $clog2(NB_MONITOR)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_enable,
    input  logic [15:0]                         i_period,
    input  logic [TARGET_W-1:0]                 i_target_sel,
    input  logic [(2**TARGET_W)*COUNT_W-1:0]    i_target_lo,
    input  logic [(2**TARGET_W)*COUNT_W-1:0]    i_target_hi,
    input  logic [NB_MONITOR-1:0]               i_mon_mask,
    output logic                                o_meas_start,
    input  logic                                i_meas_done,
    input  logic [NB_MONITOR*COUNT_W-1:0]       i_count,
    output logic                                o_req_valid,
    output logic                                o_req_up,
    input  logic                                i_req_ack,
    output logic [COUNT_W-1:0]                  o_min_count,
    output logic [IDX_W-1:0]                    o_min_idx,
    output logic                                o_busy,
    output logic                                o_timeout
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MONITOR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_MEAS,
        S_SCAN,
        S_DECIDE,
        S_REQ
    } state_t;

    state_t                          state_q, state_d;
    logic [15:0]                     wait_cnt_q, wait_cnt_d;
    logic [COUNT_W-1:0]              min_count_q, min_count_d;
    logic [IDX_W-1:0]                min_idx_q, min_idx_d;
    logic                            req_up_q, req_up_d;

    // Scan datapath: captured counts and running minimum
    logic [NB_MONITOR*COUNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]                scan_idx_q, scan_idx_d;
    logic [COUNT_W-1:0]              run_min_q, run_min_d;
    logic [IDX_W-1:0]                run_idx_q, run_idx_d;
    logic                            run_found_q, run_found_d;

    logic [COUNT_W-1:0]              cur_count;
    logic [COUNT_W-1:0]              tgt_lo;
    logic [COUNT_W-1:0]              tgt_hi;

`ifdef SVS_CONTROLLER_TIMEOUT_EN
    logic [9:0]                      tmo_cnt_q, tmo_cnt_d;
    logic                            timeout_q, timeout_d;
`endif

    // Next-state, scan and decision logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        min_count_d = min_count_q;
        min_idx_d   = min_idx_q;
        req_up_d    = req_up_q;
        cnt_d       = cnt_q;
        scan_idx_d  = scan_idx_q;
        run_min_d   = run_min_q;
        run_idx_d   = run_idx_q;
        run_found_d = run_found_q;
`ifdef SVS_CONTROLLER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
`endif
        cur_count = cnt_q[scan_idx_q*COUNT_W +: COUNT_W];
        tgt_lo    = i_target_lo[i_target_sel*COUNT_W +: COUNT_W];
        tgt_hi    = i_target_hi[i_target_sel*COUNT_W +: COUNT_W];

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_MEAS;
`ifdef SVS_CONTROLLER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_MEAS: begin
                if (i_meas_done) begin
                    cnt_d       = i_count;
                    scan_idx_d  = '0;
                    run_min_d   = '1;
                    run_idx_d   = '0;
                    run_found_d = 1'b0;
                    state_d     = S_SCAN;
                end
`ifdef SVS_CONTROLLER_TIMEOUT_EN
                else if (tmo_cnt_q == 10'h3FF) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = i_period;
                    state_d    = S_WAIT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                end
`endif
            end
            S_SCAN: begin
                // Strict less-than keeps the lowest index on ties
                if (!i_mon_mask[scan_idx_q]) begin
                    run_found_d = 1'b1;
                    if (cur_count < run_min_q) begin
                        run_min_d = cur_count;
                        run_idx_d = scan_idx_q;
                    end
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = S_DECIDE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            S_DECIDE: begin
                min_count_d = run_min_q;
                min_idx_d   = run_idx_q;
                // Low threshold wins when the window is misprogrammed (lo > hi);
                // a fully masked array never requests.
                if (run_found_q && (run_min_q < tgt_lo)) begin
                    req_up_d = 1'b1;
                    state_d  = S_REQ;
                end else if (run_found_q && (run_min_q > tgt_hi)) begin
                    req_up_d = 1'b0;
                    state_d  = S_REQ;
                end else begin
                    wait_cnt_d = i_period;
                    state_d    = S_WAIT;
                end
            end
            S_REQ: begin
                if (i_req_ack) begin
                    wait_cnt_d = i_period;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // WAIT always lasts at least one cycle, so period 0 and 1 behave alike
                if (wait_cnt_q <= 16'd1) begin
                    wait_cnt_d = '0;
                    state_d    = i_enable ? S_START : S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and published-result registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            min_count_q <= '1;
            min_idx_q   <= '0;
            req_up_q    <= 1'b0;
`ifdef SVS_CONTROLLER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            min_count_q <= min_count_d;
            min_idx_q   <= min_idx_d;
            req_up_q    <= req_up_d;
`ifdef SVS_CONTROLLER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Scan datapath registers, initialised when a measurement completes
    always_ff @(posedge i_clk) begin
        cnt_q       <= cnt_d;
        scan_idx_q  <= scan_idx_d;
        run_min_q   <= run_min_d;
        run_idx_q   <= run_idx_d;
        run_found_q <= run_found_d;
    end

    assign o_meas_start = (state_q == S_START);
    assign o_req_valid  = (state_q == S_REQ);
    assign o_req_up     = req_up_q;
    assign o_min_count  = min_count_q;
    assign o_min_idx    = min_idx_q;
    assign o_busy       = (state_q != S_IDLE);
`ifdef SVS_CONTROLLER_TIMEOUT_EN
    assign o_timeout    = timeout_q;
`else
    assign o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_svs_controller.sv
// Self-checking bench for svs_controller (scoreboard of expected round results).
module tb_svs_controller;

    localparam int NB  = 30;
    localparam int CW  = 16;
    localparam int TW  = 3;
    localparam int IW  = 5;
    localparam int NT  = 2**TW;

    typedef struct {
        logic [CW-1:0] min;
        logic [IW-1:0] idx;
        logic          req;
        logic          up;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [15:0]       period;
    logic [TW-1:0]     tsel;
    logic [NT*CW-1:0]  tlo;
    logic [NT*CW-1:0]  thi;
    logic [NB-1:0]     mask;
    logic              meas_start;
    logic              meas_done;
    logic [NB*CW-1:0]  count;
    logic              req_valid;
    logic              req_up;
    logic              ack;
    logic [CW-1:0]     min_count;
    logic [IW-1:0]     min_idx;
    logic              busy;
    logic              timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    svs_controller dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_period     (period),
        .i_target_sel (tsel),
        .i_target_lo  (tlo),
        .i_target_hi  (thi),
        .i_mon_mask   (mask),
        .o_meas_start (meas_start),
        .i_meas_done  (meas_done),
        .i_count      (count),
        .o_req_valid  (req_valid),
        .o_req_up     (req_up),
        .i_req_ack    (ack),
        .o_min_count  (min_count),
        .o_min_idx    (min_idx),
        .o_busy       (busy),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [NB*CW-1:0] c, input logic [NB-1:0] mk,
                                   input logic [CW-1:0] lo, input logic [CW-1:0] hi);
        exp_t e;
        logic found;
        e.min = '1; e.idx = '0; e.req = 1'b0; e.up = 1'b0; found = 1'b0;
        for (int m = 0; m < NB; m++) begin
            if (!mk[m]) begin
                found = 1'b1;
                if (c[m*CW +: CW] < e.min) begin
                    e.min = c[m*CW +: CW];
                    e.idx = IW'(m);
                end
            end
        end
        if (found && e.min < lo) begin
            e.req = 1'b1; e.up = 1'b1;
        end else if (found && e.min > hi) begin
            e.req = 1'b1; e.up = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [NB*CW-1:0] fill(input logic [CW-1:0] v);
        logic [NB*CW-1:0] r;
        for (int m = 0; m < NB; m++) r[m*CW +: CW] = v;
        return r;
    endfunction

    // Stimulus only: wait (bounded) for the START state
    task automatic wait_start();
        int n = 0;
        while (meas_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Called in START: completes the measurement, pushes the expected result,
    // and returns just after the DECIDE edge. drop_at >= 0 drops i_enable mid-SCAN.
    task automatic do_meas(input logic [NB*CW-1:0] c, input int drop_at);
        tick();
        count     = c;
        meas_done = 1'b1;
        sb.push_back(model(c, mask, tlo[tsel*CW +: CW], thi[tsel*CW +: CW]));
        tick();
        meas_done = 1'b0;
        for (int i = 0; i < NB + 1; i++) begin
            if (i == drop_at) en = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; period = 16'd4; tsel = '0; tlo = '0; thi = '1;
        mask = '0; meas_done = 1'b0; count = '0; ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++; if (meas_start !== 1'b0) begin n_fail++; $display("FAIL reset_meas_start got %b exp 0", meas_start); end
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
        n_checks++; if (req_up !== 1'b0) begin n_fail++; $display("FAIL reset_req_up got %b exp 0", req_up); end
        n_checks++; if (min_count !== 16'hFFFF) begin n_fail++; $display("FAIL reset_min_count got %h exp ffff", min_count); end
        n_checks++; if (min_idx !== 5'd0) begin n_fail++; $display("FAIL reset_min_idx got %0d exp 0", min_idx); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_no_request();
        exp_t e;
        int   n;
        logic saw_req;
        tsel = 3'd2;
        tlo[2*CW +: CW] = 16'h0300;
        thi[2*CW +: CW] = 16'h0500;
        period = 16'd4;
        en = 1'b1;
        tick();
        n_checks++; if (meas_start !== 1'b1) begin n_fail++; $display("FAIL start_latency got %b exp 1", meas_start); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b exp 1", busy); end
        do_meas(fill(16'h0400), -1);
        e = sb.pop_front();
        n_checks++; if (min_count !== e.min) begin n_fail++; $display("FAIL noreq_min got %h exp %h", min_count, e.min); end
        n_checks++; if (min_idx !== e.idx) begin n_fail++; $display("FAIL noreq_idx got %0d exp %0d", min_idx, e.idx); end
        n_checks++; if (req_valid !== e.req) begin n_fail++; $display("FAIL noreq_valid got %b exp %b", req_valid, e.req); end
        // Stray done/ack during WAIT must be ignored
        meas_done = 1'b1; ack = 1'b1; n = 0; saw_req = 1'b0;
        while (meas_start !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (req_valid === 1'b1) saw_req = 1'b1;
        end
        meas_done = 1'b0; ack = 1'b0;
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL period_gap got %0d cycles exp 4 (start 5 after DECIDE)", n); end
        n_checks++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL wait_req_valid got %b exp 0", saw_req); end
    endtask

    task automatic test_up_request_hold();
        exp_t e;
        logic [NB*CW-1:0] c;
        c = fill(16'h0400);
        c[17*CW +: CW] = 16'h0100;
        do_meas(c, -1);
        e = sb.pop_front();
        n_checks++; if (min_idx !== e.idx) begin n_fail++; $display("FAIL up_idx got %0d exp %0d", min_idx, e.idx); end
        n_checks++; if (min_count !== e.min) begin n_fail++; $display("FAIL up_min got %h exp %h", min_count, e.min); end
        n_checks++; if (req_valid !== e.req) begin n_fail++; $display("FAIL up_valid got %b exp %b", req_valid, e.req); end
        n_checks++; if (req_up !== e.up) begin n_fail++; $display("FAIL up_dir got %b exp %b", req_up, e.up); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (req_valid !== 1'b1 || req_up !== 1'b1) begin
                n_fail++; $display("FAIL hold_stable cycle %0d got valid=%b up=%b exp 1/1", i, req_valid, req_up);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL ack_drop got %b exp 0", req_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ack_busy got %b exp 1", busy); end
    endtask

    task automatic test_mask_tie();
        exp_t e;
        logic [NB*CW-1:0] c;
        tsel = 3'd5;
        tlo[5*CW +: CW] = 16'h0300;
        thi[5*CW +: CW] = 16'h0700;
        c = fill(16'h0800);
        c[3*CW +: CW] = 16'h0050;
        c[9*CW +: CW] = 16'h0050;
        for (int r = 0; r < 2; r++) begin
            mask = (r == 0) ? 30'h0000_0008 : 30'h0;
            wait_start();
            n_checks++; if (meas_start !== 1'b1) begin n_fail++; $display("FAIL tie_start got %b exp 1", meas_start); end
            do_meas(c, -1);
            e = sb.pop_front();
            n_checks++; if (min_idx !== e.idx) begin n_fail++; $display("FAIL tie_idx r%0d got %0d exp %0d", r, min_idx, e.idx); end
            n_checks++; if (min_count !== e.min) begin n_fail++; $display("FAIL tie_min r%0d got %h exp %h", r, min_count, e.min); end
            n_checks++; if (req_valid !== e.req || req_up !== e.up) begin n_fail++; $display("FAIL tie_req r%0d got %b/%b exp %b/%b", r, req_valid, req_up, e.req, e.up); end
            ack = 1'b1; tick(); ack = 1'b0;
        end
        // Ack held high the whole round: ignored until REQ, then a 1-cycle request
        ack = 1'b1;
        wait_start();
        do_meas(fill(16'h0800), -1);
        e = sb.pop_front();
        n_checks++; if (req_valid !== e.req || req_up !== e.up) begin n_fail++; $display("FAIL down_req got %b/%b exp %b/%b", req_valid, req_up, e.req, e.up); end
        tick();
        ack = 1'b0;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL one_cycle_req got %b exp 0", req_valid); end
    endtask

    task automatic test_all_masked_drop();
        exp_t e;
        int   n;
        logic saw_start;
        logic [NB*CW-1:0] c;
        mask = '1;
        for (int m = 0; m < NB; m++) c[m*CW +: CW] = 16'($urandom_range(0, 16'h0FFF));
        wait_start();
        do_meas(c, 10);
        e = sb.pop_front();
        n_checks++; if (min_count !== e.min) begin n_fail++; $display("FAIL masked_min got %h exp %h", min_count, e.min); end
        n_checks++; if (min_idx !== e.idx) begin n_fail++; $display("FAIL masked_idx got %0d exp %0d", min_idx, e.idx); end
        n_checks++; if (req_valid !== e.req) begin n_fail++; $display("FAIL masked_valid got %b exp %b", req_valid, e.req); end
        n = 0; saw_start = 1'b0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
            if (meas_start === 1'b1) saw_start = 1'b1;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle busy got %b exp 0", busy); end
        n_checks++; if (saw_start !== 1'b0) begin n_fail++; $display("FAIL drop_restart got %b exp 0", saw_start); end
        repeat (5) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_stay got %b exp 0", busy); end
    endtask

    task automatic test_random();
        exp_t e;
        logic [NB*CW-1:0] c;
        int   d;
        for (int k = 0; k < NT; k++) begin
            tlo[k*CW +: CW] = 16'($urandom_range(16'h0200, 16'h0900));
            thi[k*CW +: CW] = 16'($urandom_range(16'h0400, 16'h0C00));
        end
        period = 16'($urandom_range(0, 3));
        en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            tsel = TW'($urandom_range(0, NT - 1));
            mask = NB'($urandom & $urandom);
            for (int m = 0; m < NB; m++) c[m*CW +: CW] = 16'($urandom_range(0, 15) << 8);
            wait_start();
            n_checks++; if (meas_start !== 1'b1) begin n_fail++; $display("FAIL rnd_start r%0d got %b exp 1", r, meas_start); end
            do_meas(c, -1);
            e = sb.pop_front();
            n_checks++; if (min_count !== e.min || min_idx !== e.idx) begin n_fail++; $display("FAIL rnd_min r%0d got %h@%0d exp %h@%0d", r, min_count, min_idx, e.min, e.idx); end
            n_checks++; if (req_valid !== e.req) begin n_fail++; $display("FAIL rnd_valid r%0d got %b exp %b", r, req_valid, e.req); end
            if (e.req) begin
                n_checks++; if (req_up !== e.up) begin n_fail++; $display("FAIL rnd_up r%0d got %b exp %b", r, req_up, e.up); end
                d = $urandom_range(0, 3);
                repeat (d) tick();
                ack = 1'b1; tick(); ack = 1'b0;
                n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_ack r%0d got %b exp 0", r, req_valid); end
            end
        end
    endtask

    task automatic test_reset_in_req();
        exp_t e;
        logic [NB*CW-1:0] c;
        mask = '0; tsel = 3'd2; period = 16'd4; en = 1'b1;
        tlo[2*CW +: CW] = 16'h0300;
        thi[2*CW +: CW] = 16'h0500;
        c = fill(16'h0400);
        c[5*CW +: CW] = 16'h0010;
        wait_start();
        do_meas(c, -1);
        e = sb.pop_front();
        n_checks++; if (req_valid !== e.req) begin n_fail++; $display("FAIL pre_rst_valid got %b exp %b", req_valid, e.req); end
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", req_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (min_count !== 16'hFFFF || min_idx !== 5'd0) begin n_fail++; $display("FAIL rst_min got %h@%0d exp ffff@0", min_count, min_idx); end
        n_checks++; if (req_up !== 1'b0) begin n_fail++; $display("FAIL rst_up got %b exp 0", req_up); end
    endtask

`ifdef SVS_CONTROLLER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        period = 16'd2; en = 1'b1;
        wait_start();
        n = 0;
        while (timeout !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        n_checks++; if (n !== 1025) begin n_fail++; $display("FAIL timeout_latency got %0d exp 1025", n); end
        wait_start();
        n_checks++; if (meas_start !== 1'b1) begin n_fail++; $display("FAIL timeout_loop got %b exp 1", meas_start); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b exp 1", timeout); end
        rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b exp 0", timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_no_request();
        test_up_request_hold();
        test_mask_tie();
        test_all_masked_drop();
        test_random();
        test_reset_in_req();
`ifdef SVS_CONTROLLER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
